// File: rtl/axi_lite_sram_ctrl.sv
// AXI4-Lite slave bridging single-beat reads/writes onto a 1K x 32 synchronous SRAM.
// Partial-strobe writes use read-modify-write; one transaction outstanding at a time.
module axi_lite_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [9:0]  sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout,
  output logic        sram_we
);

  typedef enum logic [2:0] {
    IDLE, RD_ACC, RD_CAP, RD_RESP, WR_RD, WR_MRG, WR_DO, WR_RESP
  } state_t;

  state_t      state;
  logic        prio_rd;
  logic        rst_settle;
  logic        sram_we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        idle_ok, rd_req, wr_req, grant_rd, grant_wr, ar_hit, aw_hit;
  logic [31:0] merged;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_comb begin
    rd_req   = s_axi_arvalid;
    wr_req   = s_axi_awvalid & s_axi_wvalid;
    idle_ok  = (state == IDLE) & ~rst_settle & ~rst;
    grant_rd = idle_ok & rd_req & (~wr_req | prio_rd);
    grant_wr = idle_ok & wr_req & (~rd_req | ~prio_rd);
    ar_hit   = (s_axi_araddr[31:12] == BASE_ADDR[31:12]);
    aw_hit   = (s_axi_awaddr[31:12] == BASE_ADDR[31:12]);
  end

  always_comb begin
    merged = sram_dout;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  assign s_axi_arready = grant_rd;
  assign s_axi_awready = grant_wr;
  assign s_axi_wready  = grant_wr;

  // Reset forces a read cycle immediately, even if the registered strobe was low in WR_DO.
  assign sram_we = sram_we_q | rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prio_rd      <= 1'b1;
      rst_settle   <= 1'b1;
      sram_we_q    <= 1'b1;
      sram_addr    <= '0;
      sram_din     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= '0;
      s_axi_rdata  <= '0;
    end else begin
      rst_settle <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rd) begin
            prio_rd <= 1'b0;
            if (ar_hit) begin
              sram_addr <= s_axi_araddr[11:2];
              state     <= RD_ACC;
            end else begin
              s_axi_rdata  <= '0;
              s_axi_rresp  <= 2'b10;
              s_axi_rvalid <= 1'b1;
              state        <= RD_RESP;
            end
          end else if (grant_wr) begin
            prio_rd <= 1'b1;
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
            if (!aw_hit) begin
              s_axi_bresp  <= 2'b10;
              s_axi_bvalid <= 1'b1;
              state        <= WR_RESP;
            end else if (s_axi_wstrb == 4'h0) begin
              s_axi_bresp  <= 2'b00;
              s_axi_bvalid <= 1'b1;
              state        <= WR_RESP;
            end else if (s_axi_wstrb == 4'hF) begin
              sram_addr <= s_axi_awaddr[11:2];
              sram_din  <= s_axi_wdata;
              sram_we_q <= 1'b0;
              state     <= WR_DO;
            end else begin
              sram_addr <= s_axi_awaddr[11:2];
              state     <= WR_RD;
            end
          end
        end
        RD_ACC: state <= RD_CAP;
        RD_CAP: begin
          s_axi_rdata  <= sram_dout;
          s_axi_rresp  <= 2'b00;
          s_axi_rvalid <= 1'b1;
          state        <= RD_RESP;
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        WR_RD: state <= WR_MRG;
        WR_MRG: begin
          sram_din  <= merged;
          sram_we_q <= 1'b0;
          state     <= WR_DO;
        end
        WR_DO: begin
          sram_we_q    <= 1'b1;
          s_axi_bresp  <= 2'b00;
          s_axi_bvalid <= 1'b1;
          state        <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_ctrl.sv
// Directed bench for axi_lite_sram_ctrl: vector table of single transactions plus
// hand-written sequences for arbitration, backpressure and reset corner cases.
module tb_axi_lite_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic        sram_we;

  always #5 clk = ~clk;

  axi_lite_sram_ctrl #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .sram_we(sram_we)
  );

  // SRAM model: write when sram_we is low, registered read data.
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (sram_we == 1'b0) mem[sram_addr] <= sram_din;
    sram_dout <= mem[sram_addr];
  end

  int we_low_cnt = 0;
  int rst_we_viol = 0;
  always @(negedge clk) begin
    if (sram_we !== 1'b1) we_low_cnt++;
    if (rst === 1'b1 && sram_we !== 1'b1) rst_we_viol++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic aw_w_hs(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output bit ok);
    ok = 1'b0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (s_axi_awready && s_axi_wready) begin
        @(posedge clk); #1; ok = 1'b1; break;
      end
      @(posedge clk); #1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] addr, output bit ok);
    ok = 1'b0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (s_axi_arready) begin
        @(posedge clk); #1; ok = 1'b1; break;
      end
      @(posedge clk); #1;
    end
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp, output bit ok);
    ok = 1'b0; resp = 2'bxx;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (s_axi_bvalid) begin
        resp = s_axi_bresp; @(posedge clk); #1; ok = 1'b1; break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Entered one cycle after the AR handshake edge, so latency starts at 1.
  task automatic wait_r(output logic [31:0] data, output logic [1:0] resp,
                        output int lat, output bit ok);
    ok = 1'b0; data = 'x; resp = 2'bxx; lat = 1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (s_axi_rvalid) begin
        data = s_axi_rdata; resp = s_axi_rresp;
        @(posedge clk); #1; ok = 1'b1; break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    int          we_lows;
    string       name;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    bit          ok;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat, w0, bad, ng, rd_left, wr_left, both;
    int          order [4];

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0,         0, 1, "wr_full_004"};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 3, 0, "rd_004"};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, 2'b00, 32'h0,         0, 1, "wr_preload_008"};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0,         0, 1, "wr_rmw_008"};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD, 3, 0, "rd_merged_008"};
    vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 2'b10, 32'h0,         1, 0, "rd_oor_1000"};
    vecs[6]  = '{1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 2'b10, 32'h0,         0, 0, "wr_oor_2000"};
    vecs[7]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0,         0, 0, "wr_strb0_004"};
    vecs[8]  = '{1'b0, 32'h0000_0006, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 3, 0, "rd_lsb_006"};
    vecs[9]  = '{1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'h8, 2'b00, 32'h0,         0, 1, "wr_rmw_00c_b3"};
    vecs[10] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'hCA00_0000, 3, 0, "rd_00c_a"};
    vecs[11] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h0,         0, 1, "wr_top_ffc"};
    vecs[12] = '{1'b0, 32'h0000_0FFF, 32'h0,         4'h0, 2'b00, 32'h0BAD_F00D, 3, 0, "rd_top_fff"};
    vecs[13] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0, 2'b10, 32'h0,         1, 0, "rd_oor_hi"};
    vecs[14] = '{1'b1, 32'h0000_000C, 32'h0000_55AA, 4'h3, 2'b00, 32'h0,         0, 1, "wr_rmw_00c_lo"};
    vecs[15] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'hCA00_55AA, 3, 0, "rd_00c_b"};

    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = 32'h4;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_awaddr = 32'h10; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;

    // Reset values with both request types already pending.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_bvalid,
                       s_axi_rvalid, s_axi_bresp, s_axi_rresp, sram_we}, 32'h1);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_sram_addr", {22'h0, sram_addr}, 32'h0);
    check("rst_sram_din", sram_din, 32'h0);

    rst = 1'b0;
    #1;
    check("post_rst_ready_low", {s_axi_arready, s_axi_awready, s_axi_wready}, 32'h0);
    @(posedge clk); #1;

    // Arbitration: two reads and two writes pending together.
    rd_left = 2; wr_left = 2; ng = 0; both = 0;
    for (int c = 0; c < 100 && (rd_left > 0 || wr_left > 0); c++) begin
      #1;
      if (s_axi_arready && s_axi_awready) both++;
      if (s_axi_arready) begin
        if (ng < 4) order[ng] = 0;
        ng++; rd_left--;
      end
      if (s_axi_awready) begin
        if (ng < 4) order[ng] = 1;
        ng++; wr_left--;
      end
      @(posedge clk); #1;
      s_axi_arvalid = (rd_left > 0);
      s_axi_awvalid = (wr_left > 0);
      s_axi_wvalid  = (wr_left > 0);
    end
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("arb_grant_count", ng, 4);
    check("arb_dual_grant", both, 0);
    if (ng >= 3) begin
      check("arb_first_read", order[0], 0);
      check("arb_second_write", order[1], 1);
      check("arb_third_read", order[2], 0);
    end
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      w0 = we_low_cnt;
      if (vecs[i].wr) begin
        aw_w_hs(vecs[i].addr, vecs[i].data, vecs[i].strb, ok);
        check({vecs[i].name, "_aw_hs"}, ok, 1);
        if (ok) begin
          wait_b(resp, ok);
          check({vecs[i].name, "_b_seen"}, ok, 1);
          check({vecs[i].name, "_bresp"}, resp, vecs[i].resp);
        end
      end else begin
        ar_hs(vecs[i].addr, ok);
        check({vecs[i].name, "_ar_hs"}, ok, 1);
        if (ok) begin
          wait_r(data, resp, lat, ok);
          check({vecs[i].name, "_r_seen"}, ok, 1);
          check({vecs[i].name, "_rresp"}, resp, vecs[i].resp);
          check({vecs[i].name, "_rdata"}, data, vecs[i].rdata);
          check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
        end
      end
      check({vecs[i].name, "_we_cycles"}, we_low_cnt - w0, vecs[i].we_lows);
    end

    // AW alone must wait; then B held under bready low.
    s_axi_bready = 1'b0;
    s_axi_awaddr = 32'h14; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0;
    bad = 0;
    repeat (5) begin
      #1;
      if (s_axi_awready || s_axi_wready) bad++;
      @(posedge clk); #1;
    end
    check("aw_alone_no_ready", bad, 0);
    aw_w_hs(32'h14, 32'h0102_0304, 4'hF, ok);
    check("bp_aw_hs", ok, 1);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (s_axi_bvalid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("bp_b_seen", ok, 1);
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (!(s_axi_bvalid === 1'b1 && s_axi_bresp === 2'b00)) bad++;
    end
    check("b_held_under_backpressure", bad, 0);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    #1;
    check("b_released", s_axi_bvalid, 0);
    s_axi_bready = 1'b1;

    // R held under rready low; next grant only after the R handshake.
    s_axi_rready = 1'b0;
    ar_hs(32'h14, ok);
    check("bp_ar_hs", ok, 1);
    wait_r(data, resp, lat, ok);
    check("r_seen_bp", ok, 1);
    check("rdata_bp_first", data, 32'h0102_0304);
    bad = 0;
    repeat (3) begin
      if (!(s_axi_rvalid === 1'b1 && s_axi_rdata === 32'h0102_0304 && s_axi_rresp === 2'b00)) bad++;
      @(posedge clk); #1;
    end
    check("r_held_under_backpressure", bad, 0);
    s_axi_araddr = 32'h1000; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    #1;
    check("no_ready_during_resp", s_axi_arready, 0);
    @(posedge clk); #1;
    #1;
    check("grant_after_resp", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    #1;
    check("oor_read_immediate", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, 2'b10, 32'h0});
    @(posedge clk); #1;

    // Reset in WR_MRG of a read-modify-write.
    w0 = we_low_cnt; bad = 0;
    aw_w_hs(32'h8, 32'hFFFF_FFFF, 4'h3, ok);
    check("rmw_rst_aw_hs", ok, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    if (s_axi_bvalid) bad++;
    s_axi_araddr = 32'h8; s_axi_arvalid = 1'b1;
    rst = 1'b0;
    #1;
    if (s_axi_bvalid) bad++;
    check("rmw_rst_settle_no_ready", s_axi_arready, 0);
    @(posedge clk); #1;
    ar_hs(32'h8, ok);
    check("rmw_rst_idle_grant", ok, 1);
    wait_r(data, resp, lat, ok);
    check("rmw_rst_word_unchanged", data, 32'h11BB_33DD);

    // Reset in WR_DO: strobe must go high combinationally.
    aw_w_hs(32'h8, 32'h9999_9999, 4'hF, ok);
    check("wrdo_rst_aw_hs", ok, 1);
    rst = 1'b1;
    #1;
    check("wrdo_rst_we_gated", sram_we, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    if (s_axi_bvalid) bad++;
    check("rst_no_bvalid", bad, 0);
    check("rst_no_sram_write", we_low_cnt - w0, 0);
    ar_hs(32'h8, ok);
    check("wrdo_rst_ar_hs", ok, 1);
    wait_r(data, resp, lat, ok);
    check("wrdo_rst_word_unchanged", data, 32'h11BB_33DD);
    check("we_low_during_rst", rst_we_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
